// File: rtl/cdc_hs_tx_pkg.sv
// Shared definitions for the source side of the req/ack handshake crossing.
package cdc_hs_tx_pkg;

    // Handshake FSM encoding; IDLE must stay 2'b00 so the reset state is all zeros.
    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        WAIT_ACK_HI = 2'b01,
        WAIT_ACK_LO = 2'b10
    } hs_state_e;

    // Two flops is the minimum that gives ACK_ASYNC a full cycle to resolve metastability.
    localparam int DEFAULT_NUM_STAGES = 2;

endpackage

// File: rtl/cdc_ack_sync.sv
// Single-bit flop chain that brings the destination's ACK into the local clock domain.
// NUM_STAGES must be at least 2; the first flop may go metastable, later ones filter it.
module cdc_ack_sync
    import cdc_hs_tx_pkg::*;
#(
    parameter int NUM_STAGES = DEFAULT_NUM_STAGES
) (
    input  logic CLK,
    input  logic RST,
    input  logic async_i,
    output logic sync_o
);

    logic [NUM_STAGES-1:0] sync_q;

    // Shift the raw input through the chain; clearing to 0 makes a reset look like "ACK low".
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[NUM_STAGES-2:0], async_i};
        end
    end

    assign sync_o = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Source-domain initiator of a 4-phase req/ack handshake carrying one word per transfer.
// TX_DATA and REQ are both plain flops so the destination never sees a glitch on them,
// and the word is loaded on the same edge that raises REQ.
module cdc_hs_tx
    import cdc_hs_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_STAGES = DEFAULT_NUM_STAGES
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] SRC_DATA,
    input  logic                  SRC_VALID,
    output logic                  SRC_READY,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic                  REQ,
    input  logic                  ACK_ASYNC,
    output logic                  DONE
);

    hs_state_e             state_q, state_d;
    logic                  req_q, req_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  ack_s;
    logic                  accept;

    // The raw ACK is only ever consumed through this synchronizer.
    cdc_ack_sync #(
        .NUM_STAGES(NUM_STAGES)
    ) u_ack_sync (
        .CLK    (CLK),
        .RST    (RST),
        .async_i(ACK_ASYNC),
        .sync_o (ack_s)
    );

    // A lingering ACK from an earlier cycle (e.g. after a local reset) blocks new requests.
    assign SRC_READY = (state_q == IDLE) && !ack_s;
    assign accept    = SRC_VALID && SRC_READY;

    // Next-state logic: raise REQ on accept, drop it once ACK is seen, finish when ACK clears.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        tx_data_d = tx_data_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    tx_data_d = SRC_DATA;
                    req_d     = 1'b1;
                    state_d   = WAIT_ACK_HI;
                end
            end
            WAIT_ACK_HI: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = WAIT_ACK_LO;
                end
            end
            WAIT_ACK_LO: begin
                if (!ack_s) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State, request, data and completion flops; reset drops REQ without waiting for a clock.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            done_q    <= 1'b0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            done_q    <= done_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign REQ     = req_q;
    assign DONE    = done_q;
    assign TX_DATA = tx_data_q;

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Bench for cdc_hs_tx: directed handshake scenarios plus a random soak, all checked
// against a transfer-level reference model of the source side of the protocol.
module tb_cdc_hs_tx;

    localparam int DW          = 8;
    localparam int NS_A        = 2;
    localparam int NS_B        = 3;
    localparam int WAIT_BUDGET = 60;

    logic          clock = 1'b0;
    logic          rstN;
    logic [1:0]    srcValid;
    logic [DW-1:0] srcData [2];
    logic [1:0]    ackManual;
    logic          respEn;
    logic          respAck;
    int            respDelay;
    logic          ackA;

    logic          readyA, reqA, doneA;
    logic          readyB, reqB, doneB;
    logic [DW-1:0] txDataA, txDataB;

    int vectorCount     = 0;
    int miscompareCount = 0;
    int cyc             = 0;

    // Reference model state: one word in flight, whether ACK has been seen, and the
    // history of ACK values sampled at each clock edge since the last reset.
    bit            mBusy;
    bit            mSeenHi;
    bit            mReq;
    bit            mDone;
    logic [DW-1:0] mTx;
    bit            ackHist [$];

    assign ackA = respEn ? respAck : ackManual[0];

    cdc_hs_tx #(.DATA_WIDTH(DW), .NUM_STAGES(NS_A)) dutA (
        .CLK      (clock),
        .RST      (rstN),
        .SRC_DATA (srcData[0]),
        .SRC_VALID(srcValid[0]),
        .SRC_READY(readyA),
        .TX_DATA  (txDataA),
        .REQ      (reqA),
        .ACK_ASYNC(ackA),
        .DONE     (doneA)
    );

    cdc_hs_tx #(.DATA_WIDTH(DW), .NUM_STAGES(NS_B)) dutB (
        .CLK      (clock),
        .RST      (rstN),
        .SRC_DATA (srcData[1]),
        .SRC_VALID(srcValid[1]),
        .SRC_READY(readyB),
        .TX_DATA  (txDataB),
        .REQ      (reqB),
        .ACK_ASYNC(ackManual[1]),
        .DONE     (doneB)
    );

    always #5 clock = ~clock;

    // Edge counter used to measure latencies in whole cycles.
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic getReq(input int which);
        return (which == 0) ? reqA : reqB;
    endfunction

    function automatic logic getDone(input int which);
        return (which == 0) ? doneA : doneB;
    endfunction

    function automatic logic getReady(input int which);
        return (which == 0) ? readyA : readyB;
    endfunction

    function automatic logic [DW-1:0] getTx(input int which);
        return (which == 0) ? txDataA : txDataB;
    endfunction

    // The ACK level the design acts on at the next edge: the raw ACK as it was NS_A edges ago.
    function automatic bit syncedAck();
        if (ackHist.size() >= NS_A) return ackHist[ackHist.size() - NS_A];
        return 1'b0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            miscompareCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int which, input logic valid, input logic [DW-1:0] data);
        @(posedge clock);
        #1;
        srcValid[which] = valid;
        srcData[which]  = data;
    endtask

    task automatic setAck(input int which, input logic level);
        @(posedge clock);
        #1;
        ackManual[which] = level;
    endtask

    task automatic waitReq(input int which, input logic level, output int seenCyc);
        seenCyc = -1;
        for (int i = 0; i < WAIT_BUDGET; i++) begin
            @(negedge clock);
            if (getReq(which) == level) begin
                seenCyc = cyc;
                break;
            end
        end
        if (seenCyc < 0) checkOutput("req_wait_timeout", 32'(getReq(which)), 32'(level));
    endtask

    task automatic waitDone(input int which, output int seenCyc);
        seenCyc = -1;
        for (int i = 0; i < WAIT_BUDGET; i++) begin
            @(negedge clock);
            if (getDone(which)) begin
                seenCyc = cyc;
                break;
            end
        end
        if (seenCyc < 0) checkOutput("done_wait_timeout", 32'(getDone(which)), 1);
    endtask

    // One word through a manually driven destination: ACK rises 3 cycles after REQ and
    // falls 3 cycles after REQ drops. Returns ACK-rise-to-REQ-fall and ACK-fall-to-DONE cycles.
    task automatic singleTransfer(input int which, input logic [DW-1:0] word,
                                  output int reqLat, output int doneLat);
        int seen;
        int tAck;
        reqLat  = -1;
        doneLat = -1;
        applyStimulus(which, 1'b1, word);
        applyStimulus(which, 1'b0, word);
        @(negedge clock);
        checkOutput("single_req_rise", 32'(getReq(which)), 1);
        checkOutput("single_tx_data", 32'(getTx(which)), 32'(word));
        repeat (2) @(posedge clock);
        setAck(which, 1'b1);
        tAck = cyc;
        waitReq(which, 1'b0, seen);
        if (seen >= 0) reqLat = seen - tAck;
        repeat (2) @(posedge clock);
        setAck(which, 1'b0);
        tAck = cyc;
        waitDone(which, seen);
        if (seen >= 0) doneLat = seen - tAck;
        @(negedge clock);
        checkOutput("single_done_width", 32'(getDone(which)), 0);
        checkOutput("single_ready_back", 32'(getReady(which)), 1);
    endtask

    // Destination responder for DUT A: echoes REQ onto ACK after respDelay cycles each way.
    initial begin
        int hiCnt;
        int loCnt;
        respAck = 1'b0;
        hiCnt   = 0;
        loCnt   = 0;
        forever begin
            @(posedge clock);
            #1;
            if (!respEn) begin
                respAck = 1'b0;
                hiCnt   = 0;
                loCnt   = 0;
            end else if (reqA && !respAck) begin
                hiCnt++;
                if (hiCnt >= respDelay) begin
                    respAck = 1'b1;
                    hiCnt   = 0;
                end
            end else if (!reqA && respAck) begin
                loCnt++;
                if (loCnt >= respDelay) begin
                    respAck = 1'b0;
                    loCnt   = 0;
                end
            end
        end
    end

    // Reference model for DUT A: a word is taken only when idle with ACK seen low,
    // REQ drops once ACK is seen high, and the transfer finishes when ACK is seen low again.
    always @(posedge clock or negedge rstN) begin
        bit ackSeen;
        if (!rstN) begin
            ackHist.delete();
            mBusy   = 1'b0;
            mSeenHi = 1'b0;
            mReq    = 1'b0;
            mDone   = 1'b0;
            mTx     = '0;
        end else begin
            ackSeen = syncedAck();
            mDone   = 1'b0;
            if (!mBusy) begin
                if (srcValid[0] && !ackSeen) begin
                    mBusy   = 1'b1;
                    mSeenHi = 1'b0;
                    mReq    = 1'b1;
                    mTx     = srcData[0];
                end
            end else if (!mSeenHi) begin
                if (ackSeen) begin
                    mSeenHi = 1'b1;
                    mReq    = 1'b0;
                end
            end else if (!ackSeen) begin
                mBusy = 1'b0;
                mDone = 1'b1;
            end
            ackHist.push_back(ackA);
        end
    end

    // Compare every observable output of DUT A with the model once per cycle.
    always @(negedge clock) begin
        checkOutput("model_req", 32'(reqA), 32'(mReq));
        checkOutput("model_tx_data", 32'(txDataA), 32'(mTx));
        checkOutput("model_done", 32'(doneA), 32'(mDone));
        checkOutput("model_src_ready", 32'(readyA), 32'(!mBusy && !syncedAck()));
    end

    // Hard stop in case a scenario loses its way entirely.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: time limit reached before summary");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios, random soak, then the deeper-synchronizer regression.
    initial begin
        int latReqA, latDoneA, latReqB, latDoneB;
        int seen, tDrop;
        bit doneSeen;

        rstN        = 1'b0;
        srcValid    = '0;
        srcData[0]  = '0;
        srcData[1]  = '0;
        ackManual   = '0;
        respEn      = 1'b0;
        respDelay   = 3;

        repeat (3) @(posedge clock);
        #1 rstN = 1'b1;
        @(negedge clock);
        checkOutput("reset_req", 32'(reqA), 0);
        checkOutput("reset_tx_data", 32'(txDataA), 0);
        checkOutput("reset_done", 32'(doneA), 0);
        checkOutput("reset_ready_a", 32'(readyA), 1);
        checkOutput("reset_ready_b", 32'(readyB), 1);

        $display("[TB] single transfer, NUM_STAGES=%0d", NS_A);
        singleTransfer(0, 8'hA5, latReqA, latDoneA);
        checkOutput("lat_req_window_a", 32'(latReqA >= NS_A && latReqA <= NS_A + 1), 1);
        checkOutput("lat_done_window_a", 32'(latDoneA >= NS_A && latDoneA <= NS_A + 1), 1);

        $display("[TB] back-to-back with busy-time data churn");
        respEn    = 1'b1;
        respDelay = 3;
        applyStimulus(0, 1'b1, 8'h01);
        waitReq(0, 1'b1, seen);
        checkOutput("b2b_first_tx", 32'(txDataA), 32'h01);
        applyStimulus(0, 1'b1, 8'h02);
        waitDone(0, seen);
        checkOutput("b2b_not_early", 32'(reqA), 0);
        @(negedge clock);
        checkOutput("b2b_second_req", 32'(reqA), 1);
        checkOutput("b2b_second_tx", 32'(txDataA), 32'h02);
        doneSeen = 1'b0;
        for (int i = 0; i < WAIT_BUDGET; i++) begin
            @(posedge clock);
            #1;
            if (doneA) begin
                srcValid[0] = 1'b0;
                doneSeen    = 1'b1;
                break;
            end
            srcData[0] = 8'($urandom);
        end
        if (!doneSeen) checkOutput("busy_done_timeout", 32'(doneA), 1);
        srcValid[0] = 1'b0;
        @(negedge clock);
        checkOutput("busy_tx_hold", 32'(txDataA), 32'h02);

        $display("[TB] stray ACK while idle");
        respEn = 1'b0;
        setAck(0, 1'b1);
        repeat (NS_A + 1) @(posedge clock);
        applyStimulus(0, 1'b1, 8'h5A);
        repeat (4) @(posedge clock);
        @(negedge clock);
        checkOutput("stray_no_req", 32'(reqA), 0);
        checkOutput("stray_ready_low", 32'(readyA), 0);
        setAck(0, 1'b0);
        tDrop = cyc;
        waitReq(0, 1'b1, seen);
        checkOutput("stray_accept_lat", 32'((seen - tDrop) >= NS_A && (seen - tDrop) <= NS_A + 1), 1);
        checkOutput("stray_tx", 32'(txDataA), 32'h5A);
        applyStimulus(0, 1'b0, 8'h5A);
        respEn = 1'b1;
        waitDone(0, seen);
        respEn = 1'b0;

        $display("[TB] reset in the middle of a transfer");
        applyStimulus(0, 1'b1, 8'hC3);
        applyStimulus(0, 1'b0, 8'hC3);
        setAck(0, 1'b1);
        @(posedge clock);
        #3;
        checkOutput("midrst_req_before", 32'(reqA), 1);
        rstN = 1'b0;
        #1;
        checkOutput("midrst_req_async", 32'(reqA), 0);
        checkOutput("midrst_done_async", 32'(doneA), 0);
        checkOutput("midrst_tx_async", 32'(txDataA), 0);
        repeat (2) @(posedge clock);
        #1 rstN = 1'b1;
        repeat (NS_A + 1) @(posedge clock);
        @(negedge clock);
        checkOutput("postrst_ready_low", 32'(readyA), 0);
        applyStimulus(0, 1'b1, 8'h3C);
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("postrst_no_req", 32'(reqA), 0);
        setAck(0, 1'b0);
        waitReq(0, 1'b1, seen);
        checkOutput("postrst_tx", 32'(txDataA), 32'h3C);
        applyStimulus(0, 1'b0, 8'h3C);
        respEn = 1'b1;
        waitDone(0, seen);

        $display("[TB] random soak");
        for (int i = 0; i < 400; i++) begin
            @(posedge clock);
            #1;
            srcValid[0] = 1'($urandom_range(0, 1));
            srcData[0]  = 8'($urandom);
            if ((i % 37) == 0) respDelay = int'($urandom_range(1, 6));
        end
        srcValid[0] = 1'b0;
        doneSeen = 1'b0;
        for (int i = 0; i < WAIT_BUDGET; i++) begin
            @(negedge clock);
            if (!reqA && readyA && !respAck) begin
                doneSeen = 1'b1;
                break;
            end
        end
        if (!doneSeen) checkOutput("soak_idle_timeout", 32'(readyA), 1);
        respEn = 1'b0;

        $display("[TB] single transfer, NUM_STAGES=%0d", NS_B);
        singleTransfer(1, 8'hA5, latReqB, latDoneB);
        checkOutput("lat_req_window_b", 32'(latReqB >= NS_B && latReqB <= NS_B + 1), 1);
        checkOutput("lat_done_window_b", 32'(latDoneB >= NS_B && latDoneB <= NS_B + 1), 1);
        checkOutput("lat_req_growth", 32'(latReqB - latReqA), 1);
        checkOutput("lat_done_growth", 32'(latDoneB - latDoneA), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule
